slt_share_arbiter: RTL

//  Shares one subtract-based set-less-than compare unit among NUM_REQ requesters.

---
 rtl/slt_arb_pkg.sv | 16 +
 rtl/slt_core.sv | 24 ++
 rtl/slt_share_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/slt_arb_pkg.sv
// Shared types and constants for the shared set-less-than compare arbiter.
package slt_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_RESP
  } state_e;

  localparam logic OP_SLT  = 1'b0;
  localparam logic OP_SLTU = 1'b1;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/slt_core.sv
// Combinational subtract-based set-less-than: one adder plus signed-overflow detect.
module slt_core #(
  parameter int WIDTH = slt_arb_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             lt,
  output logic             ovf
);

  logic             carry;
  logic             diff_msb;
  logic [WIDTH-2:0] diff_unused;
  logic             v;

  // A - B as A + ~B + 1; the carry out means "no borrow", i.e. A >= B unsigned.
  assign {carry, diff_msb, diff_unused} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign v   = (a[WIDTH-1] == ~b[WIDTH-1]) & (diff_msb != a[WIDTH-1]);
  assign lt  = is_unsigned ? ~carry : (diff_msb ^ v);
  assign ovf = is_unsigned ? 1'b0 : v;

endmodule

// File: rtl/slt_share_arbiter.sv
// Round-robin arbiter sharing one slt_core among NUM_REQ requesters,
// sequenced by an IDLE/COMPUTE/RESP FSM with a tagged valid/ready response.
module slt_share_arbiter
  import slt_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  WIDTH   = DEF_WIDTH,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_unsigned,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_lt,
  output logic                     rsp_ovf
);

  state_e             state_q,     state_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic               op_q,        op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
  logic               rsp_lt_q,    rsp_lt_d;
  logic               rsp_ovf_q,   rsp_ovf_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     scan_idx;
  logic               core_lt;
  logic               core_ovf;

  // Scan starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_id) : '0;

  slt_core #(.WIDTH(WIDTH)) u_core (
    .a           (a_q),
    .b           (b_q),
    .is_unsigned (op_q == OP_SLTU),
    .lt          (core_lt),
    .ovf         (core_ovf)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_ovf_d   = rsp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          a_d      = req_a[grant_id*WIDTH +: WIDTH];
          b_d      = req_b[grant_id*WIDTH +: WIDTH];
          op_d     = req_unsigned[grant_id];
          rr_ptr_d = grant_id;
          state_d  = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        rsp_lt_d    = core_lt;
        rsp_ovf_d   = core_ovf;
        rsp_id_d    = rr_ptr_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      // NOTE: operand registers are cleared too, so the compare path never starts from X.
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_SLT;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_lt_q    <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule
